// File: rtl/snake_pixel_engine.sv
// Snake game state and pixel colour stage behind the VGA timing generator.
// The game advances once per FRAMES_PER_STEP frames; RGB is registered.
module snake_pixel_engine #(
  parameter int CELL_SHIFT      = 4,
  parameter int GRID_W          = 40,
  parameter int GRID_H          = 30,
  parameter int MAX_LEN         = 16,
  parameter int FRAMES_PER_STEP = 8
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       displayArea,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic [7:0] score,
  output logic       gameOver
);

  localparam int CNT_W =
    (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(FRAMES_PER_STEP - 1);

  localparam logic [5:0]  AX0   = 6'd30;
  localparam logic [4:0]  AY0   = 5'd15;
  localparam logic [4:0]  LEN0  = 5'd3;
  localparam logic [15:0] LFSR0 = 16'hACE1;

  localparam logic [11:0] C_HEAD = 12'hFF0;
  localparam logic [11:0] C_BODY = 12'h0F0;
  localparam logic [11:0] C_APPL = 12'hF00;
  localparam logic [11:0] C_DEAD = 12'h400;
  localparam logic [11:0] C_NONE = 12'h000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_e;

  typedef enum logic [1:0] {
    D_UP,
    D_DOWN,
    D_LEFT,
    D_RIGHT
  } dir_e;

  function automatic dir_e opp(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

  // Initial snake lies horizontally, head at (20,15)
  function automatic logic [5:0] seg_x0(input int i);
    return (i < 3) ? 6'(20 - i) : 6'd0;
  endfunction

  function automatic logic [4:0] seg_y0(input int i);
    return (i < 3) ? 5'd15 : 5'd0;
  endfunction

  state_e state_q, state_d;
  dir_e   dir_q, dir_d;
  dir_e   last_q, last_d;
  logic [4:0]  len_q, len_d;
  logic [5:0]  seg_x_q [MAX_LEN];
  logic [5:0]  seg_x_d [MAX_LEN];
  logic [4:0]  seg_y_q [MAX_LEN];
  logic [4:0]  seg_y_d [MAX_LEN];
  logic [5:0]  apple_x_q, apple_x_d;
  logic [4:0]  apple_y_q, apple_y_d;
  logic [7:0]  score_q, score_d;
  logic        over_q, over_d;
  logic        seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [11:0] rgb_q, rgb_d;

  logic       any_btn;
  logic       frame_tick;
  logic       step;
  logic       move;
  logic       init;
  logic       req_v;
  dir_e       req;
  logic [6:0] dx, dy;
  logic [6:0] nx, ny;
  logic [5:0] hx;
  logic [4:0] hy;
  logic       wall;
  logic       eat;
  logic       self_hit;
  logic [4:0] lim;
  logic [5:0] new_ax;
  logic [4:0] new_ay;
  logic [5:0] cell_x, cell_y;
  logic       is_head, is_body, is_apple;

  assign any_btn = btnUp | btnDown | btnLeft | btnRight;
  assign frame_tick = (xCount == 10'd0) && (yCount == 10'd480);
  assign step = frame_tick && (state_q == S_RUN)
             && (cnt_q == CNT_LAST);

  always_comb begin
    req_v = 1'b1;
    req   = D_RIGHT;
    priority case (1'b1)
      btnUp:    req = D_UP;
      btnDown:  req = D_DOWN;
      btnLeft:  req = D_LEFT;
      btnRight: req = D_RIGHT;
      default:  req_v = 1'b0;
    endcase
  end

  // Head arithmetic is 7-bit two's complement so x/y = -1 reads as a wall
  always_comb begin
    dx = 7'd0;
    dy = 7'd0;
    unique case (dir_q)
      D_UP:    dy = 7'h7F;
      D_DOWN:  dy = 7'd1;
      D_LEFT:  dx = 7'h7F;
      D_RIGHT: dx = 7'd1;
    endcase
    nx = {1'b0, seg_x_q[0]} + dx;
    ny = {2'b00, seg_y_q[0]} + dy;
    hx = nx[5:0];
    hy = ny[4:0];
    wall = nx[6] | ny[6]
         | (nx[5:0] >= 6'(GRID_W))
         | (ny[5:0] >= 6'(GRID_H));
    eat = !wall && (hx == apple_x_q) && (hy == apple_y_q);
    lim = eat ? len_q : len_q - 5'd1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < lim) && (seg_x_q[i] == hx)
          && (seg_y_q[i] == hy))
        self_hit = 1'b1;
    end
    new_ax = (lfsr_q[5:0] >= 6'(GRID_W))
           ? lfsr_q[5:0] - 6'(GRID_W) : lfsr_q[5:0];
    new_ay = (lfsr_q[12:8] >= 5'(GRID_H))
           ? lfsr_q[12:8] - 5'(GRID_H) : lfsr_q[12:8];
  end

  assign move = step && !wall && !self_hit;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    last_d    = last_q;
    len_d     = len_q;
    seg_x_d   = seg_x_q;
    seg_y_d   = seg_y_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    seen_d    = 1'b0;
    init      = 1'b0;
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};

    if (frame_tick && (state_q == S_RUN))
      cnt_d = step ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: if (any_btn) state_d = S_RUN;
      S_RUN: if (step && (wall || self_hit)) state_d = S_DEAD;
      S_DEAD: begin
        seen_d = seen_q | ~any_btn;
        if (any_btn && seen_q) begin
          state_d = S_IDLE;
          init    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (move) begin
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      seg_x_d[0] = hx;
      seg_y_d[0] = hy;
      last_d     = dir_q;
      if (eat) begin
        len_d = (len_q == 5'(MAX_LEN)) ? len_q : len_q + 5'd1;
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        apple_x_d = new_ax;
        apple_y_d = new_ay;
      end
    end

    // Compared with the post-move heading so a late press cannot reverse
    if (req_v && (req != opp(last_d)))
      dir_d = req;

    if (init) begin
      dir_d  = D_RIGHT;
      last_d = D_RIGHT;
      len_d  = LEN0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x0(i);
        seg_y_d[i] = seg_y0(i);
      end
      apple_x_d = AX0;
      apple_y_d = AY0;
      score_d   = 8'd0;
      cnt_d     = '0;
    end

    over_d = (state_d == S_DEAD);
  end

  assign cell_x = 6'(xCount >> CELL_SHIFT);
  assign cell_y = 6'(yCount >> CELL_SHIFT);

  always_comb begin
    is_head = (cell_x == seg_x_q[0])
           && (cell_y == {1'b0, seg_y_q[0]});
    is_apple = (cell_x == apple_x_q)
            && (cell_y == {1'b0, apple_y_q});
    is_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (cell_x == seg_x_q[i])
          && (cell_y == {1'b0, seg_y_q[i]}))
        is_body = 1'b1;
    end
    rgb_d = C_NONE;
    if (!displayArea)
      rgb_d = C_NONE;
    else if (is_head)
      rgb_d = C_HEAD;
    else if (is_body)
      rgb_d = C_BODY;
    else if (is_apple)
      rgb_d = C_APPL;
    else if (state_q == S_DEAD)
      rgb_d = C_DEAD;
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= D_RIGHT;
      last_q  <= D_RIGHT;
      len_q   <= LEN0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x0(i);
        seg_y_q[i] <= seg_y0(i);
      end
      apple_x_q <= AX0;
      apple_y_q <= AY0;
      score_q   <= 8'd0;
      over_q    <= 1'b0;
      seen_q    <= 1'b0;
      cnt_q     <= '0;
      lfsr_q    <= LFSR0;
      rgb_q     <= 12'h000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      last_q    <= last_d;
      len_q     <= len_d;
      seg_x_q   <= seg_x_d;
      seg_y_q   <= seg_y_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      score_q   <= score_d;
      over_q    <= over_d;
      seen_q    <= seen_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      rgb_q     <= rgb_d;
    end
  end

  assign VGA_R    = rgb_q[11:8];
  assign VGA_G    = rgb_q[7:4];
  assign VGA_B    = rgb_q[3:0];
  assign score    = score_q;
  assign gameOver = over_q;

endmodule

// File: tb/tb_snake_pixel_engine.sv
// Scoreboard bench for snake_pixel_engine: drives raster probes and
// frame ticks directly and checks RGB/score/gameOver against a model.
module tb_snake_pixel_engine;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;
  localparam int IDLE = 0, RUN = 1, DEAD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = '0, y = '0;
  logic       de = 1'b0;
  logic       bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic [3:0] r, g, b;
  logic [7:0] score;
  logic       go;

  always #5 clk = ~clk;

  snake_pixel_engine dut (
    .VGA_clk    (clk),
    .reset      (reset),
    .xCount     (x),
    .yCount     (y),
    .displayArea(de),
    .btnUp      (bu),
    .btnDown    (bd),
    .btnLeft    (bl),
    .btnRight   (br),
    .VGA_R      (r),
    .VGA_G      (g),
    .VGA_B      (b),
    .score      (score),
    .gameOver   (go)
  );

  int n_tot = 0;
  int n_bad = 0;
  int exp_q[$];

  logic [15:0] m_lfsr;
  always @(posedge clk)
    m_lfsr <= reset ? 16'hACE1
            : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
               m_lfsr[15:1]};

  int mx [16];
  int my [16];
  int mlen, mdir, mlast, mcnt, ax, ay, mscore, mstate;
  bit mseen;

  task automatic chk(string tag, int got, int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 16; i++) begin
      mx[i] = (i < 3) ? 20 - i : 0;
      my[i] = (i < 3) ? 15 : 0;
    end
    mlen = 3; ax = 30; ay = 15; mscore = 0;
    mdir = RIGHT; mlast = RIGHT; mcnt = 0; mstate = IDLE;
  endtask

  function automatic int model_pix(int cx, int cy);
    if (cx == mx[0] && cy == my[0]) return 'hFF0;
    for (int i = 1; i < mlen; i++)
      if (cx == mx[i] && cy == my[i]) return 'h0F0;
    if (cx == ax && cy == ay) return 'hF00;
    return (mstate == DEAD) ? 'h400 : 'h000;
  endfunction

  task automatic cyc();
    bit was_dead;
    was_dead = (mstate == DEAD);
    @(posedge clk);
    #1;
    if (was_dead) mseen = 1'b1;
  endtask

  task automatic probe(int px, int py, bit pde, int exp);
    x = 10'(px);
    y = 10'(py);
    de = pde;
    exp_q.push_back(exp);
    cyc();
    chk($sformatf("rgb@%0d,%0d,de%0d", px, py, pde),
        int'({r, g, b}), exp_q.pop_front());
  endtask

  task automatic probe_cell(int cx, int cy);
    if (cx < 0 || cx >= 40 || cy < 0 || cy >= 30) return;
    probe(cx * 16 + int'($urandom_range(0, 15)),
          cy * 16 + int'($urandom_range(0, 15)), 1'b1,
          model_pix(cx, cy));
  endtask

  task automatic check_board();
    int t;
    probe_cell(mx[0], my[0]);
    probe_cell(mx[0] + 1, my[0]);
    probe_cell(mx[0] - 1, my[0]);
    probe_cell(mx[0], my[0] + 1);
    probe_cell(mx[0], my[0] - 1);
    for (int i = 1; i < mlen; i++) probe_cell(mx[i], my[i]);
    t = mlen - 1;
    probe_cell(mx[t] + 1, my[t]);
    probe_cell(mx[t] - 1, my[t]);
    probe_cell(mx[t], my[t] + 1);
    probe_cell(mx[t], my[t] - 1);
    probe_cell(ax, ay);
    probe(mx[0] * 16 + 8, my[0] * 16 + 8, 1'b0, 0);
  endtask

  task automatic do_step(logic [15:0] lf);
    int nx, ny, lim;
    bit eat, hit;
    nx = mx[0] + ((mdir == RIGHT) ? 1 : (mdir == LEFT) ? -1 : 0);
    ny = my[0] + ((mdir == DOWN) ? 1 : (mdir == UP) ? -1 : 0);
    if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
      mstate = DEAD; mseen = 1'b0;
      return;
    end
    eat = (nx == ax && ny == ay);
    lim = eat ? mlen : mlen - 1;
    hit = 1'b0;
    for (int i = 0; i < lim; i++)
      if (mx[i] == nx && my[i] == ny) hit = 1'b1;
    if (hit) begin
      mstate = DEAD; mseen = 1'b0;
      return;
    end
    for (int i = 15; i > 0; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    mx[0] = nx; my[0] = ny; mlast = mdir;
    if (eat) begin
      if (mlen < 16) mlen++;
      if (mscore < 255) mscore++;
      ax = int'(lf[5:0]) % 40;
      ay = int'(lf[12:8]) % 30;
    end
  endtask

  task automatic tick();
    logic [15:0] lf;
    x = '0; y = 10'd480; de = 1'b0;
    lf = m_lfsr;
    cyc();
    x = 10'd1; y = '0;
    if (mstate == RUN) begin
      if (mcnt == 7) begin
        mcnt = 0;
        do_step(lf);
      end else mcnt++;
    end
    chk("score", int'(score), mscore);
    chk("gameOver", int'(go), int'(mstate == DEAD));
  endtask

  task automatic run_ticks(int n);
    repeat (n) begin
      tick();
      check_board();
    end
  endtask

  task automatic press(logic [3:0] btn);
    int req;
    x = 10'd1; y = '0; de = 1'b0;
    {bu, bd, bl, br} = btn;
    @(posedge clk);
    #1;
    {bu, bd, bl, br} = 4'b0000;
    req = btn[3] ? UP : btn[2] ? DOWN : btn[1] ? LEFT : RIGHT;
    if (mstate == DEAD) begin
      if (mseen) model_init();
    end else begin
      if (mstate == IDLE) mstate = RUN;
      if (req != (mlast ^ 1)) mdir = req;
    end
    chk("gameOver_press", int'(go), int'(mstate == DEAD));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $fatal(1);
  end

  initial begin
    model_init();
    mseen = 1'b0;
    x = 10'd328; y = 10'd248; de = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", int'({r, g, b}), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_over", int'(go), 0);
    reset = 1'b0;
    probe(328, 248, 1'b1, 'hFF0);
    check_board();

    press(4'b0001);
    run_ticks(8);
    press(4'b0010);
    run_ticks(8);
    press(4'b1010);
    run_ticks(8);

    run_ticks(8 * 14 + 7);
    tick();
    press(4'b0100);
    check_board();
    press(4'b0100);
    chk("restart_score", int'(score), 0);
    check_board();
    probe(328, 248, 1'b1, 'hFF0);

    press(4'b0001);
    run_ticks(8 * 12);
    chk("eat_score", int'(score), 1);

    reset = 1'b1;
    probe(mx[0] * 16 + 8, my[0] * 16 + 8, 1'b1, 0);
    reset = 1'b0;
    model_init();
    mseen = 1'b0;
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_over", int'(go), 0);
    check_board();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
